// File: rtl/shift_operand_stage.sv
// Shift operand stage: decodes the rotated-immediate or shifted-register operand and registers it for the barrel shifter.
// Define SHIFT_OPERAND_SKID_EN for a 2-entry skid buffer (full rate); otherwise a single half-rate output register.

module shift_operand_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         imm_op,
    input  logic [7:0]   imm8,
    input  logic [3:0]   rot4,
    input  logic [1:0]   sh_type,
    input  logic         sh_reg,
    input  logic [4:0]   imm5,
    input  logic [W-1:0] rm_data,
    input  logic [7:0]   rs_data,
    input  logic [3:0]   in_tag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sh_data,
    output logic [4:0]   sh_amt,
    output logic [1:0]   sh_ctrl,
    output logic [3:0]   out_tag,
    output logic         amt_big
);

    typedef struct packed {
        logic [W-1:0] data;
        logic [4:0]   amt;
        logic [1:0]   ctrl;
        logic [3:0]   tag;
        logic         big;
    } entry_t;

    entry_t dec;
    entry_t out_q, out_d;
    logic   out_valid_q, out_valid_d;
    logic   accept;

    assign accept = in_valid && in_ready && !flush;

    // Immediates are an 8-bit value rotated right by twice rot4; register
    // amounts of 32 or more are flagged so the shifter can saturate.
    always_comb begin
        dec     = '0;
        dec.tag = in_tag;
        if (imm_op) begin
            dec.data = W'(imm8);
            dec.ctrl = 2'b11;
            dec.amt  = {rot4, 1'b0};
            dec.big  = 1'b0;
        end else begin
            dec.data = rm_data;
            dec.ctrl = sh_type;
            if (sh_reg) begin
                dec.amt = rs_data[4:0];
                dec.big = |rs_data[7:5];
            end else begin
                dec.amt = imm5;
                dec.big = 1'b0;
            end
        end
    end

`ifdef SHIFT_OPERAND_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;

    // The skid entry catches the transaction accepted in the cycle the
    // output stalls, and always drains into the output register first.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready     <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready     <= !skid_valid_d;
        end
    end
`else
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_ready    <= !out_valid_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign sh_data   = out_q.data;
    assign sh_amt    = out_q.amt;
    assign sh_ctrl   = out_q.ctrl;
    assign out_tag   = out_q.tag;
    assign amt_big   = out_q.big;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Scoreboard bench for shift_operand_stage: random and directed transactions against a behavioural operand model.
// Build with or without SHIFT_OPERAND_SKID_EN; throughput and flush expectations follow the macro.

module tb_shift_operand_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         imm_op = 1'b0;
    logic [7:0]   imm8 = '0;
    logic [3:0]   rot4 = '0;
    logic [1:0]   sh_type = '0;
    logic         sh_reg = 1'b0;
    logic [4:0]   imm5 = '0;
    logic [W-1:0] rm_data = '0;
    logic [7:0]   rs_data = '0;
    logic [3:0]   in_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sh_data;
    logic [4:0]   sh_amt;
    logic [1:0]   sh_ctrl;
    logic [3:0]   out_tag;
    logic         amt_big;

    typedef struct packed {
        logic         imm_op;
        logic [7:0]   imm8;
        logic [3:0]   rot4;
        logic [1:0]   sh_type;
        logic         sh_reg;
        logic [4:0]   imm5;
        logic [W-1:0] rm_data;
        logic [7:0]   rs_data;
        logic [3:0]   tag;
    } txn_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic [4:0]   amt;
        logic [1:0]   ctrl;
        logic [3:0]   tag;
        logic         big;
    } exp_t;

    exp_t exp_q[$];
    int   n_vectors = 0;
    int   n_miscompares = 0;

    shift_operand_stage #(.W(W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .imm_op(imm_op), .imm8(imm8), .rot4(rot4),
        .sh_type(sh_type), .sh_reg(sh_reg), .imm5(imm5),
        .rm_data(rm_data), .rs_data(rs_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .sh_data(sh_data), .sh_amt(sh_amt), .sh_ctrl(sh_ctrl),
        .out_tag(out_tag), .amt_big(amt_big)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Operand semantics: immediate rotates by 2*rot4, register amounts >= 32 are "big".
    function automatic exp_t ref_model(txn_t t);
        exp_t e;
        e.tag = t.tag;
        if (t.imm_op) begin
            e.data = W'(t.imm8);
            e.ctrl = 2'd3;
            e.amt  = 5'(2 * t.rot4);
            e.big  = 1'b0;
        end else begin
            e.data = t.rm_data;
            e.ctrl = t.sh_type;
            if (t.sh_reg) begin
                e.amt = 5'(t.rs_data % 32);
                e.big = (t.rs_data >= 32);
            end else begin
                e.amt = t.imm5;
                e.big = 1'b0;
            end
        end
        return e;
    endfunction

    function automatic txn_t random_txn();
        txn_t t;
        t.imm_op  = 1'($urandom_range(0, 1));
        t.imm8    = 8'($urandom);
        t.rot4    = 4'($urandom);
        t.sh_type = 2'($urandom);
        t.sh_reg  = 1'($urandom_range(0, 1));
        t.imm5    = 5'($urandom);
        t.rm_data = W'($urandom);
        t.rs_data = 8'($urandom);
        t.tag     = 4'($urandom);
        return t;
    endfunction

    function automatic txn_t inputs_now();
        txn_t t;
        t.imm_op  = imm_op;
        t.imm8    = imm8;
        t.rot4    = rot4;
        t.sh_type = sh_type;
        t.sh_reg  = sh_reg;
        t.imm5    = imm5;
        t.rm_data = rm_data;
        t.rs_data = rs_data;
        t.tag     = in_tag;
        return t;
    endfunction

    task automatic check_output(string name, logic [63:0] act, logic [63:0] req);
        n_vectors++;
        if (act !== req) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic apply_stimulus(txn_t t, logic v);
        in_valid = v;
        imm_op   = t.imm_op;
        imm8     = t.imm8;
        rot4     = t.rot4;
        sh_type  = t.sh_type;
        sh_reg   = t.sh_reg;
        imm5     = t.imm5;
        rm_data  = t.rm_data;
        rs_data  = t.rs_data;
        in_tag   = t.tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus side: every accepted input pushes its expected operand.
    always @(negedge clk) begin
        if (reset_n && in_valid && in_ready && !flush)
            exp_q.push_back(ref_model(inputs_now()));
    end

    // Monitor: pops on each consumed output, checks hold-while-stalled and one-cycle latency.
    initial begin : monitor
        exp_t got, held, e;
        logic prev_stall;
        logic expect_valid;
        prev_stall   = 1'b0;
        expect_valid = 1'b0;
        held         = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                exp_q.delete();
                prev_stall   = 1'b0;
                expect_valid = 1'b0;
                continue;
            end
            got.data = sh_data;
            got.amt  = sh_amt;
            got.ctrl = sh_ctrl;
            got.tag  = out_tag;
            got.big  = amt_big;
            if (expect_valid)
                check_output("latency_valid", 64'(out_valid), 64'(1));
            if (prev_stall) begin
                check_output("stall_valid", 64'(out_valid), 64'(1));
                check_output("stall_hold", 64'(got), 64'(held));
            end
            expect_valid = in_valid && in_ready && !flush && !out_valid;
            prev_stall   = out_valid && !out_ready && !flush;
            held         = got;
            if (flush) begin
                exp_q.delete();
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vectors++;
                    n_miscompares++;
                    $display("[TB] FAIL unexpected_out: got tag %0d, expected no output at %0t", out_tag, $time);
                end else begin
                    e = exp_q.pop_front();
                    check_output("sb_data", 64'(got), 64'(e));
                end
            end
        end
    end

    task automatic drain();
        bit done;
        done      = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            done = !out_valid && in_ready;
        end
        if (!done) check_output("drain_timeout", 64'(out_valid), 64'(0));
    endtask

    task automatic send_one(txn_t t);
        bit ok;
        ok = 1'b0;
        apply_stimulus(t, 1'b1);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check_output("send_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic stream(int n, int stall_lo, int stall_hi, int tag_base,
                          output int first_acc, output int last_acc);
        int   sent;
        int   cyc;
        txn_t t;
        sent      = 0;
        cyc       = 0;
        first_acc = 0;
        last_acc  = 0;
        while (sent < n && cyc < 200) begin
            t         = random_txn();
            t.tag     = 4'(tag_base + sent);
            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            apply_stimulus(t, 1'b1);
            @(negedge clk);
            if (in_ready) begin
                if (sent == 0) first_acc = cyc;
                last_acc = cyc;
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sent < n) check_output("stream_timeout", 64'(sent), 64'(n));
    endtask

    initial begin : stimulus
        txn_t t;
        int   first_acc, last_acc;
        int   held_entries;

        // Reset state
        #1;
        check_output("reset_in_ready", 64'(in_ready), 64'(0));
        check_output("reset_out_valid", 64'(out_valid), 64'(0));
        check_output("reset_fields", 64'({sh_data, sh_amt, sh_ctrl, out_tag, amt_big}), 64'(0));
        #22;
        reset_n = 1'b1;
        #1;
        check_output("ready_before_edge", 64'(in_ready), 64'(0));
        tick();
        check_output("ready_after_edge", 64'(in_ready), 64'(1));

        // Rotated immediate
        drain();
        t = '0;
        t.imm_op = 1'b1; t.imm8 = 8'hFF; t.rot4 = 4'd4; t.tag = 4'd1;
        send_one(t);
        check_output("imm_valid", 64'(out_valid), 64'(1));
        check_output("imm_data", 64'(sh_data), 64'h0000_00FF);
        check_output("imm_ctrl", 64'(sh_ctrl), 64'(3));
        check_output("imm_amt", 64'(sh_amt), 64'(8));
        check_output("imm_big", 64'(amt_big), 64'(0));

        // Register-specified ASR with large amount
        drain();
        t = '0;
        t.sh_reg = 1'b1; t.sh_type = 2'b10; t.rm_data = 32'h8000_0000; t.rs_data = 8'h25; t.tag = 4'd2;
        send_one(t);
        check_output("reg_data", 64'(sh_data), 64'h8000_0000);
        check_output("reg_ctrl", 64'(sh_ctrl), 64'(2));
        check_output("reg_amt", 64'(sh_amt), 64'(5));
        check_output("reg_big", 64'(amt_big), 64'(1));

        // Throughput with continuous out_ready
        drain();
        stream(8, 1000, 1000, 0, first_acc, last_acc);
`ifdef SHIFT_OPERAND_SKID_EN
        check_output("throughput_span", 64'(last_acc - first_acc), 64'(7));
`else
        check_output("throughput_span", 64'(last_acc - first_acc), 64'(14));
`endif

        // Back-to-back tags 0..7 with a 3-cycle downstream stall
        drain();
        stream(8, 3, 5, 0, first_acc, last_acc);
        drain();
        check_output("stall_sb_empty", 64'(exp_q.size()), 64'(0));

        // Flush with buffer full and a pending input
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            t = random_txn();
            t.tag = 4'd13;
            apply_stimulus(t, 1'b1);
            @(negedge clk);
            if (!in_ready) break;
            tick();
        end
        #2;
        held_entries = exp_q.size();
`ifdef SHIFT_OPERAND_SKID_EN
        check_output("flush_held", 64'(held_entries), 64'(2));
`else
        check_output("flush_held", 64'(held_entries), 64'(1));
`endif
        tick();
        t = random_txn();
        t.tag = 4'd15;
        apply_stimulus(t, 1'b1);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_output("flush_out_valid", 64'(out_valid), 64'(0));
        check_output("flush_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("flush_no_output", 64'(out_valid), 64'(0));
        end

        // Asynchronous reset while holding an output
        drain();
        out_ready = 1'b0;
        t = '0;
        t.rm_data = 32'hDEAD_BEEF; t.sh_type = 2'b01; t.imm5 = 5'd7; t.tag = 4'd9;
        send_one(t);
        check_output("pre_reset_valid", 64'(out_valid), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async_reset_valid", 64'(out_valid), 64'(0));
        check_output("async_reset_fields", 64'({sh_data, sh_amt, sh_ctrl, out_tag, amt_big}), 64'(0));
        check_output("async_reset_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #3;
        check_output("hold_reset_ready", 64'(in_ready), 64'(0));
        reset_n = 1'b1;
        #1;
        check_output("release_ready_pre", 64'(in_ready), 64'(0));
        tick();
        check_output("release_ready_post", 64'(in_ready), 64'(1));
        check_output("release_valid", 64'(out_valid), 64'(0));

        // Random traffic with occasional flush
        for (int i = 0; i < 800; i++) begin
            apply_stimulus(random_txn(), 1'($urandom_range(0, 3) != 0));
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 24) == 0);
            tick();
        end
        drain();
        check_output("final_sb_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
